// File: rtl/mem_responder.sv
// Word-organised RAM responder with valid/ready request and response channels
// and a fixed number of wait states between request acceptance and the access.
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_wstrb,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  fsm_state
);

    localparam int          AW    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_WAIT   = 2'b01,
        S_RESP   = 2'b10,
        S_UNUSED = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic          in_range;
    logic          access;
    logic          mem_we;
    logic [31:0]   merged;

    // Range check uses the full captured address, so high bits cannot alias in.
    always_comb begin
        idx      = addr_q[AW+1:2];
        in_range = ({1'b0, addr_q} < LIMIT);
        merged   = mem[idx];
        for (int unsigned i = 0; i < 4; i++) begin
            if (wstrb_q[i]) begin
                merged[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        access  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wstrb_d = req_wstrb;
                    wdata_d = req_wdata;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    access  = 1'b1;
                    rdata_d = in_range ? merged : '0;
                    err_d   = !in_range;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        mem_we = access && in_range && (wstrb_q != 4'b0000);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM is not reset, but a reset on the access edge must still suppress the write.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem[idx] <= merged;
        end
    end

    always_comb begin
        req_ready  = (state_q == S_IDLE);
        resp_valid = (state_q == S_RESP);
        resp_rdata = rdata_q;
        resp_err   = err_q;
        fsm_state  = state_q;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance with two wait states, one with none.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;

    logic        req_valid, req_ready, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [3:0]  req_wstrb;
    logic [1:0]  fsm_state;

    logic        req_valid0, req_ready0, resp_valid0, resp_ready0, resp_err0;
    logic [31:0] req_addr0, req_wdata0, resp_rdata0;
    logic [3:0]  req_wstrb0;
    logic [1:0]  fsm_state0;

    mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) dut2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wstrb(req_wstrb), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .fsm_state(fsm_state)
    );

    mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_addr(req_addr0),
        .req_wstrb(req_wstrb0), .req_wdata(req_wdata0),
        .resp_valid(resp_valid0), .resp_ready(resp_ready0), .resp_rdata(resp_rdata0),
        .resp_err(resp_err0), .fsm_state(fsm_state0)
    );

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;
    int hs2    = 0;
    int hs0    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t q2[$];
    exp_t q0[$];
    exp_t e2, e0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        failed++;
        $display("FAIL %s: timed out waiting, expected DUT event", name);
    endtask

    // Monitors: pop and compare on every response handshake.
    always @(negedge clk) begin
        if (reset === 1'b0 && resp_valid && resp_ready) begin
            if (q2.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL resp2_unexpected: got rdata 0x%08h, expected no response", resp_rdata);
            end else begin
                e2 = q2.pop_front();
                chk("resp2_rdata", resp_rdata, e2.rdata);
                chk("resp2_err", {31'b0, resp_err}, {31'b0, e2.err});
                hs2++;
            end
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b0 && resp_valid0 && resp_ready0) begin
            if (q0.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL resp0_unexpected: got rdata 0x%08h, expected no response", resp_rdata0);
            end else begin
                e0 = q0.pop_front();
                chk("resp0_rdata", resp_rdata0, e0.rdata);
                chk("resp0_err", {31'b0, resp_err0}, {31'b0, e0.err});
                hs0++;
            end
        end
    end

    task automatic wait_ready2(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) timeout({name, "_ready"});
    endtask

    // Issue one request; returns at the first negedge where resp_valid is seen.
    task automatic txn2(input string name, input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
        int   k, n;
        exp_t e;
        wait_ready2(name);
        e.rdata = exp_rdata;
        e.err   = exp_err;
        q2.push_back(e);
        req_addr  = addr;
        req_wstrb = strb;
        req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = ~wdata;
        req_addr  = addr ^ 32'h4;
        req_wstrb = ~strb;
        @(negedge clk);
        k = cyc;
        n = 0;
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_latency"}, cyc - k, 32'd3);
    endtask

    task automatic rst_write(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                             input int d);
        wait_ready2(name);
        req_addr  = addr;
        req_wstrb = 4'b1111;
        req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (d) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk({name, "_state"}, {30'b0, fsm_state}, 32'd0);
        chk({name, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
        chk({name, "_req_ready"}, {31'b0, req_ready}, 32'd1);
        chk({name, "_rdata"}, resp_rdata, 32'd0);
        repeat (6) @(negedge clk);
    endtask

    logic [31:0] a0 [4];
    logic [3:0]  s0 [4];
    logic [31:0] d0 [4];
    logic [31:0] x0 [4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        int   hsb, last, acc, n;
        exp_t e;

        reset = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_wstrb = '0; req_wdata = '0; resp_ready = 1'b1;
        req_valid0 = 1'b0; req_addr0 = '0; req_wstrb0 = '0; req_wdata0 = '0; resp_ready0 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state", {30'b0, fsm_state}, 32'd0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'b0, resp_err}, 32'd0);
        chk("rst0_req_ready", {31'b0, req_ready0}, 32'd1);
        reset = 1'b0;

        txn2("wr_full",   32'h10, 4'b1111, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        txn2("rd_full",   32'h10, 4'b0000, 32'h0,        32'hDEADBEEF, 1'b0);
        txn2("wr_byte1",  32'h10, 4'b0010, 32'h0000AA00, 32'hDEADAAEF, 1'b0);
        txn2("rd_alias",  32'h13, 4'b0000, 32'h0,        32'hDEADAAEF, 1'b0);
        txn2("wr_b30",    32'h10, 4'b1001, 32'h11223344, 32'h11ADAA44, 1'b0);
        txn2("wr_zero",   32'h0,  4'b1111, 32'h12345678, 32'h12345678, 1'b0);
        txn2("wr_oor",    32'h1000, 4'b1111, 32'h55555555, 32'h0,      1'b1);
        txn2("rd_zero",   32'h0,  4'b0000, 32'h0,        32'h12345678, 1'b0);
        txn2("wr_oor_hi", 32'h80000010, 4'b1111, 32'h0,  32'h0,        1'b1);
        txn2("rd_oor_hi", 32'h80000010, 4'b0000, 32'h0,  32'h0,        1'b1);
        txn2("rd_10",     32'h10, 4'b0000, 32'h0,        32'h11ADAA44, 1'b0);
        txn2("wr_last",   32'hFFC, 4'b1111, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0);
        txn2("rd_last",   32'hFFC, 4'b0000, 32'h0,       32'hCAFEF00D, 1'b0);
        txn2("wr_20",     32'h20, 4'b1111, 32'h0,        32'h0,        1'b0);

        rst_write("rst_wait2", 32'h20, 32'hFFFFFFFF, 1);
        txn2("rd_20_a", 32'h20, 4'b0000, 32'h0, 32'h0, 1'b0);
        rst_write("rst_access", 32'h20, 32'hFFFFFFFF, 2);
        txn2("rd_20_b", 32'h20, 4'b0000, 32'h0, 32'h0, 1'b0);

        // Back-pressure: response held five edges, handshake on the sixth.
        wait_ready2("hold_pre");
        resp_ready = 1'b0;
        txn2("hold", 32'h10, 4'b0000, 32'h0, 32'h11ADAA44, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", {31'b0, resp_valid}, 32'd1);
            chk("hold_rdata", resp_rdata, 32'h11ADAA44);
            chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
            if (i < 4) @(negedge clk);
        end
        @(posedge clk);
        #1;
        hsb = hs2;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("hold_state_before_hs", {30'b0, fsm_state}, 32'd2);
        @(negedge clk);
        chk("hold_state_after_hs", {30'b0, fsm_state}, 32'd0);
        chk("hold_hs_count", hs2 - hsb, 32'd1);

        // Zero wait states, req_valid held high across back-to-back requests.
        a0[0] = 32'h40; s0[0] = 4'b1111; d0[0] = 32'hA5A50001; x0[0] = 32'hA5A50001;
        a0[1] = 32'h44; s0[1] = 4'b1111; d0[1] = 32'h0BADF00D; x0[1] = 32'h0BADF00D;
        a0[2] = 32'h40; s0[2] = 4'b0000; d0[2] = 32'h0;        x0[2] = 32'hA5A50001;
        a0[3] = 32'h44; s0[3] = 4'b0000; d0[3] = 32'h0;        x0[3] = 32'h0BADF00D;
        for (int j = 0; j < 4; j++) begin
            e.rdata = x0[j];
            e.err   = 1'b0;
            q0.push_back(e);
        end
        @(negedge clk);
        req_addr0 = a0[0]; req_wstrb0 = s0[0]; req_wdata0 = d0[0]; req_valid0 = 1'b1;
        last = 0;
        for (int j = 0; j < 4; j++) begin
            n = 0;
            while (!req_ready0 && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!req_ready0) timeout("ws0_accept");
            acc = cyc;
            if (j > 0) chk("ws0_gap", acc - last, 32'd3);
            last = acc;
            @(posedge clk);
            #1;
            if (j < 3) begin
                req_addr0 = a0[j+1]; req_wstrb0 = s0[j+1]; req_wdata0 = d0[j+1];
            end else begin
                req_valid0 = 1'b0;
            end
            @(negedge clk);
        end
        n = 0;
        while ((q0.size() != 0 || q2.size() != 0) && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("q2_drained", q2.size(), 32'd0);
        chk("q0_drained", q0.size(), 32'd0);
        chk("ws0_hs_count", hs0, 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle RV32I core: serves the word reads and byte-enabled writes the control FSM issues (MEMREAD, MEMWRITE, FETCH).
- Holds a word-organised RAM behind a valid/ready request channel and a valid/ready response channel.
- Adds a programmable number of wait states so the core's memory timing can be stressed.
- Sits between the core's address mux (AdrSrc) and the data/instruction registers.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, at least 2.
- WAIT_STATES, 2, extra cycles between request acceptance and the memory access; range 0..15.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  byte address; bits [1:0] ignored.
- req_wstrb  in  4  byte enables; 0 = read, nonzero = write, bit i writes byte lane i (bits 8i+7:8i). Same encoding as the core's MemWrite.
- req_wdata  in  32  write data, lane-aligned.
- resp_valid  out  1  response available.
- resp_ready  in  1  core accepts the response.
- resp_rdata  out  32  read data, or the post-write word for writes.
- resp_err  out  1  address out of range.
- fsm_state  out  2  current state encoding, for debug.

Behaviour:
One clock; reset is synchronous and active-high, ports named clk and reset.

States:
- IDLE=2'b00, WAIT=2'b01, RESP=2'b10. 2'b11 is unused and returns to IDLE on the next edge.

Reset:
- State goes to IDLE, with req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
- Internal wait counter and captured request fields go to 0.
- RAM contents are not reset.

Outputs and state, all registered or decoded purely from state:
- req_ready=1 only in IDLE.
- resp_valid=1 only in RESP.
- IDLE: on an edge with req_valid=1, capture addr, wstrb and wdata, set cnt=WAIT_STATES, go to WAIT. Otherwise stay in IDLE.
- WAIT: each edge, if cnt!=0 then decrement cnt. If cnt==0, perform the access and go to RESP.
- Access, in-range write: for each i with wstrb[i]=1, ram[idx] byte i <= wdata byte i. Other bytes are unchanged. resp_rdata <= the merged word. resp_err <= 0.
- Access, in-range read: resp_rdata <= ram[idx]. resp_err <= 0.
- Access, out of range (req_addr >= 4*DEPTH_WORDS, compared on the full 32 bits): no RAM write, resp_rdata <= 0, resp_err <= 1.
- RESP: hold resp_rdata and resp_err stable. On an edge with resp_ready=1, go to IDLE. Otherwise stay.

Word index and latency:
- idx = req_addr[log2(DEPTH_WORDS)+1:2].
- The request handshake at edge k gives resp_valid=1 after edge k+WAIT_STATES+1.
- The earliest next acceptance is the edge after the response handshake, since req_ready rises in IDLE. Maximum throughput is one transaction per WAIT_STATES+3 cycles.

Boundary conditions:
- req_valid or req_wdata changing while not in IDLE is ignored; only the captured values are used.
- If resp_ready is already high when RESP is entered, the response completes after one cycle in RESP.
- Reset mid-WAIT: the transaction is dropped, no RAM write occurs, and no response is issued.
- Reset in RESP: the response is discarded, and any RAM write already performed persists.
- Reset takes priority over all transitions on the same edge.
- WAIT_STATES=0: the access happens on the first edge in WAIT.
- Addresses with bits [1:0] != 0 alias to the containing word. No misalignment error is raised; the core supplies lane-aligned strobes.

Test Plan:
- WAIT_STATES=2. Write 0xDEADBEEF, wstrb=4'b1111, addr 0x10 at edge k. Required: resp_valid after edge k+3, resp_rdata=0xDEADBEEF, resp_err=0. Then read 0x10: resp_rdata=0xDEADBEEF.
- Byte write to addr 0x10, wstrb=4'b0010, wdata=0x0000AA00. Required: response rdata=0xDEADAAEF. A read of addr 0x13 returns 0xDEADAAEF (alias).
- DEPTH_WORDS=1024. Write to addr 0x00001000. Required: resp_err=1, resp_rdata=0. Then read 0x0 (0x0 last written 0x12345678): still 0x12345678.
- Read response with resp_ready held low 5 cycles. Required: resp_valid=1 and resp_rdata constant throughout, req_ready=0 throughout, and a single handshake on the 6th edge.
- Assert reset during the 2nd WAIT cycle of a write of 0xFFFFFFFF to 0x20 (0x20 holds 0x0). Required: next cycle state=IDLE, resp_valid=0, req_ready=1. A later read of 0x20 returns 0x0.
- req_valid held high for two back-to-back reads with resp_ready=1, WAIT_STATES=0. Required: acceptances 3 cycles apart, two responses each with the correct data.
